// File: rtl/s2p_stereo_rx_pkg.sv
// Shared definitions for the stereo serial receiver: FSM states, default
// sample width and the Frame polarity convention.
package s2p_stereo_rx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

  localparam int AUDIO_IN_W = 16;

  // Frame is active-high: a single high Sclk cycle marks the MSB.
  localparam logic FRAME_ACTIVE = 1'b1;

  function automatic logic frame_hit(input logic frame_s);
    return (frame_s == FRAME_ACTIVE);
  endfunction

endpackage

// File: rtl/s2p_shift_chan.sv
// One receive channel: serial shift register plus the parallel word register
// that holds the last complete word.
module s2p_shift_chan
  import s2p_stereo_rx_pkg::*;
#(
  parameter int DATA_W = AUDIO_IN_W
) (
  input  logic              Sclk,
  input  logic              Reset,
  input  logic              start,
  input  logic              shift,
  input  logic              load,
  input  logic              bit_in,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] shift_r;
  logic [DATA_W-1:0] dout_r;
  logic [DATA_W-1:0] word_s;

  // Completed word is the shifted history plus the bit sampled this edge
  always_comb begin
    word_s = {shift_r[DATA_W-2:0], bit_in};
  end

  // Shift register: start seeds the MSB, load clears it for the next word
  always_ff @(posedge Sclk or posedge Reset) begin
    if (Reset) begin
      shift_r <= '0;
    end else if (start) begin
      shift_r <= {{(DATA_W-1){1'b0}}, bit_in};
    end else if (load) begin
      shift_r <= '0;
    end else if (shift) begin
      shift_r <= word_s;
    end else begin
      shift_r <= shift_r;
    end
  end

  // Output word register, updated only when a word completes
  always_ff @(posedge Sclk or posedge Reset) begin
    if (Reset) begin
      dout_r <= '0;
    end else if (load) begin
      dout_r <= word_s;
    end else begin
      dout_r <= dout_r;
    end
  end

  assign dout = dout_r;

endmodule

// File: rtl/s2p_stereo_rx.sv
// Stereo serial-to-parallel receiver: one shared FSM and bit counter drive
// identical left and right shift channels.
module s2p_stereo_rx
  import s2p_stereo_rx_pkg::*;
#(
  parameter int DATA_W = AUDIO_IN_W,
  parameter int CNT_W  = 6
) (
  input  logic              Sclk,
  input  logic              Reset,
  input  logic              Frame,
  input  logic              InputL,
  input  logic              InputR,
  output logic [DATA_W-1:0] InputdataL,
  output logic [DATA_W-1:0] InputdataR,
  output logic              InReady,
  output logic              FrameErr,
  output logic              RxBusy
);

  if ((DATA_W < 2) || ((64'd1 << CNT_W) <= 64'(DATA_W))) begin : g_param_check
    $error("s2p_stereo_rx: DATA_W must be >= 2 and 2**CNT_W must exceed DATA_W");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  rx_state_t        state_r;
  logic [CNT_W-1:0] bitcnt_r;
  logic             in_ready_r;
  logic             frame_err_r;
  logic             rx_busy_r;

  logic             frame_s;
  logic             last_s;
  logic             start_s;
  logic             shift_s;
  logic             load_s;

  // Datapath controls decoded from the current state and sampled Frame
  always_comb begin
    frame_s = frame_hit(Frame);
    last_s  = (bitcnt_r == LAST_CNT);
    start_s = frame_s;
    shift_s = 1'b0;
    load_s  = 1'b0;
    if (state_r == SHIFT) begin
      shift_s = !frame_s && !last_s;
      load_s  = !frame_s && last_s;
    end else begin
      shift_s = 1'b0;
      load_s  = 1'b0;
    end
  end

  // Control FSM with registered strobes and busy flag
  always_ff @(posedge Sclk or posedge Reset) begin
    if (Reset) begin
      state_r     <= IDLE;
      bitcnt_r    <= '0;
      in_ready_r  <= 1'b0;
      frame_err_r <= 1'b0;
      rx_busy_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          in_ready_r  <= 1'b0;
          frame_err_r <= 1'b0;
          if (frame_s) begin
            state_r   <= SHIFT;
            bitcnt_r  <= ONE_CNT;
            rx_busy_r <= 1'b1;
          end else begin
            state_r   <= IDLE;
            bitcnt_r  <= bitcnt_r;
            rx_busy_r <= 1'b0;
          end
        end
        SHIFT: begin
          if (frame_s) begin
            // Early frame: drop the partial word and restart on this bit
            state_r     <= SHIFT;
            bitcnt_r    <= ONE_CNT;
            in_ready_r  <= 1'b0;
            frame_err_r <= 1'b1;
            rx_busy_r   <= 1'b1;
          end else if (last_s) begin
            state_r     <= IDLE;
            bitcnt_r    <= '0;
            in_ready_r  <= 1'b1;
            frame_err_r <= 1'b0;
            rx_busy_r   <= 1'b0;
          end else begin
            state_r     <= SHIFT;
            bitcnt_r    <= bitcnt_r + ONE_CNT;
            in_ready_r  <= 1'b0;
            frame_err_r <= 1'b0;
            rx_busy_r   <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          bitcnt_r    <= '0;
          in_ready_r  <= 1'b0;
          frame_err_r <= 1'b0;
          rx_busy_r   <= 1'b0;
        end
      endcase
    end
  end

  s2p_shift_chan #(.DATA_W(DATA_W)) u_chan_l (
    .Sclk   (Sclk),
    .Reset  (Reset),
    .start  (start_s),
    .shift  (shift_s),
    .load   (load_s),
    .bit_in (InputL),
    .dout   (InputdataL)
  );

  s2p_shift_chan #(.DATA_W(DATA_W)) u_chan_r (
    .Sclk   (Sclk),
    .Reset  (Reset),
    .start  (start_s),
    .shift  (shift_s),
    .load   (load_s),
    .bit_in (InputR),
    .dout   (InputdataR)
  );

  assign InReady  = in_ready_r;
  assign FrameErr = frame_err_r;
  assign RxBusy   = rx_busy_r;

endmodule

// File: tb/tb_s2p_stereo_rx.sv
// Scoreboard bench for s2p_stereo_rx: a 16-bit instance for the main scenarios
// and a 40-bit instance for the wide-word case.
module tb_s2p_stereo_rx;

  logic        Sclk;
  logic        Reset;

  logic        frame, in_l, in_r;
  logic [15:0] data_l, data_r;
  logic        rdy, ferr, busy;

  logic        frame40, l40, r40;
  logic [39:0] data_l40, data_r40;
  logic        rdy40, ferr40, busy40;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];

  s2p_stereo_rx #(.DATA_W(16), .CNT_W(6)) dut (
    .Sclk       (Sclk),
    .Reset      (Reset),
    .Frame      (frame),
    .InputL     (in_l),
    .InputR     (in_r),
    .InputdataL (data_l),
    .InputdataR (data_r),
    .InReady    (rdy),
    .FrameErr   (ferr),
    .RxBusy     (busy)
  );

  s2p_stereo_rx #(.DATA_W(40), .CNT_W(6)) dut40 (
    .Sclk       (Sclk),
    .Reset      (Reset),
    .Frame      (frame40),
    .InputL     (l40),
    .InputR     (r40),
    .InputdataL (data_l40),
    .InputdataR (data_r40),
    .InReady    (rdy40),
    .FrameErr   (ferr40),
    .RxBusy     (busy40)
  );

  initial Sclk = 1'b0;
  always #5 Sclk = ~Sclk;

  always @(posedge Sclk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, expv, cyc);
    end
  endtask

  // Scoreboard monitor: every strobe must match the head of its queue
  always @(negedge Sclk) begin
    if (!Reset) begin
      if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        check_eq("ready_missing", 64'(exp_q[0].cyc), 64'(cyc));
        void'(exp_q.pop_front());
      end
      if (err_q.size() != 0 && err_q[0] < cyc) begin
        check_eq("ferr_missing", 64'(err_q[0]), 64'(cyc));
        void'(err_q.pop_front());
      end
      if (rdy) begin
        if (exp_q.size() == 0) begin
          check_eq("ready_unexpected", 64'(1), 64'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("ready_cycle", 64'(cyc), 64'(e.cyc));
          check_eq("word_l", 64'(data_l), 64'(e.l));
          check_eq("word_r", 64'(data_r), 64'(e.r));
        end
      end
      if (ferr) begin
        if (err_q.size() == 0) check_eq("ferr_unexpected", 64'(1), 64'(0));
        else check_eq("ferr_cycle", 64'(cyc), 64'(err_q.pop_front()));
      end
      if (rdy || ferr) check_eq("ready_ferr_excl", 64'(rdy & ferr), 64'(0));
    end
  end

  task automatic send_word(input logic [15:0] l, input logic [15:0] r, input logic early);
    int c0;
    exp_t e;
    c0 = cyc;
    if (early) err_q.push_back(c0 + 1);
    e.l = l;
    e.r = r;
    e.cyc = c0 + 16;
    exp_q.push_back(e);
    for (int i = 0; i < 16; i++) begin
      frame = (i == 0);
      in_l  = l[15-i];
      in_r  = r[15-i];
      @(posedge Sclk);
      #1;
    end
    frame = 1'b0;
  endtask

  task automatic send_partial(input logic [15:0] l, input int n);
    for (int i = 0; i < n; i++) begin
      frame = (i == 0);
      in_l  = l[15-i];
      in_r  = ~l[15-i];
      @(posedge Sclk);
      #1;
    end
    frame = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Sclk);
      #1;
    end
  endtask

  initial begin
    logic [39:0] w40_l;
    logic [39:0] w40_r;
    int          busy_cnt;

    Reset = 1'b1;
    frame = 1'b0; in_l = 1'b0; in_r = 1'b0;
    frame40 = 1'b0; l40 = 1'b0; r40 = 1'b0;
    idle(3);
    Reset = 1'b0;

    // Reset state and quiet idle period
    for (int i = 0; i < 20; i++) begin
      check_eq("idle_data_l", 64'(data_l), 64'(0));
      check_eq("idle_data_r", 64'(data_r), 64'(0));
      check_eq("idle_ready", 64'(rdy), 64'(0));
      check_eq("idle_ferr", 64'(ferr), 64'(0));
      check_eq("idle_busy", 64'(busy), 64'(0));
      idle(1);
    end

    // Single word, then confirm the word register holds
    send_word(16'hA5C3, 16'h0F0F, 1'b0);
    idle(4);
    check_eq("hold_l", 64'(data_l), 64'(16'hA5C3));
    check_eq("hold_r", 64'(data_r), 64'(16'h0F0F));

    // Three back-to-back words with no idle gap
    send_word(16'h0001, 16'hFFFE, 1'b0);
    send_word(16'h8000, 16'h7FFF, 1'b0);
    send_word(16'hFFFF, 16'h0000, 1'b0);
    idle(3);

    // Early frame after 9 bits aborts the word
    send_partial(16'h1234, 9);
    send_word(16'hBEEF, 16'h4321, 1'b1);
    idle(3);

    // Early frame exactly at the last-bit position
    send_partial(16'hDEAD, 15);
    send_word(16'hC0DE, 16'h3C3C, 1'b1);
    idle(3);
    check_eq("after_abort_l", 64'(data_l), 64'(16'hC0DE));

    // Asynchronous reset mid-word after a good word
    send_word(16'h5555, 16'hAAAA, 1'b0);
    idle(2);
    send_partial(16'h1357, 7);
    check_eq("busy_before_rst", 64'(busy), 64'(1));
    #2;
    Reset = 1'b1;
    #1;
    check_eq("rst_data_l", 64'(data_l), 64'(0));
    check_eq("rst_data_r", 64'(data_r), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_ready", 64'(rdy), 64'(0));
    @(negedge Sclk);
    Reset = 1'b0;
    @(posedge Sclk);
    #1;
    send_word(16'h00FF, 16'hFF00, 1'b0);
    idle(3);

    // Wide 40-bit word; busy covers every edge after the MSB through the last bit
    w40_l = 40'h80_0000_0001;
    w40_r = 40'h7F_FFFF_FFFE;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      frame40 = (i == 0);
      l40 = w40_l[39-i];
      r40 = w40_r[39-i];
      @(posedge Sclk);
      #1;
      if (busy40) busy_cnt++;
      if (i < 39) check_eq("w40_no_ready", 64'(rdy40), 64'(0));
    end
    frame40 = 1'b0;
    check_eq("w40_ready", 64'(rdy40), 64'(1));
    check_eq("w40_data_l", 64'(data_l40), 64'(w40_l));
    check_eq("w40_data_r", 64'(data_r40), 64'(w40_r));
    check_eq("w40_busy_cycles", 64'(busy_cnt), 64'(39));
    check_eq("w40_ferr", 64'(ferr40), 64'(0));
    idle(1);
    check_eq("w40_ready_one_cycle", 64'(rdy40), 64'(0));
    idle(2);

    check_eq("exp_queue_drained", 64'(exp_q.size()), 64'(0));
    check_eq("ferr_queue_drained", 64'(err_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
